plot_capture: RTL and testbench
===============================

Name: plot_capture

Overview:
- Receiving end of the pixel-plot interface that the drawing engines (circle, Reuleaux, fill) drive: vga_x/vga_y/vga_colour/vga_plot.
- Clips each plot to the 160x120 screen and converts it to a linear framebuffer address.
- Buffers plots in a small FIFO and writes them to the framebuffer memory over a valid/ready write port.
- Also performs a full-screen clear to a given colour on request.

Parameters:
- FB_WIDTH, 160, pixels per line.
- FB_HEIGHT, 120, lines per frame.
- FIFO_DEPTH, 4, plot buffer entries; power of 2, minimum 2.
- CNT_W, 16, width of the drop and clip counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  plot strobe; one pixel per cycle while high
- clear  in  1  start full-screen clear; level sampled
- clear_colour  in  3  colour used for clear; sampled when clear is accepted
- clear_done  out  1  one-cycle pulse when the clear finishes
- busy  out  1  high while in CLEAR, or while the FIFO is non-empty
- mem_addr  out  15  framebuffer address, y*FB_WIDTH + x
- mem_data  out  3  framebuffer write data
- mem_we  out  1  write valid
- mem_ready  in  1  write accepted when mem_we && mem_ready
- drop_count  out  CNT_W  plots lost to a full FIFO; saturating
- clip_count  out  CNT_W  plots outside the screen; saturating

Behaviour:
- **Reset** (rst high at a posedge):
  - state = IDLE; FIFO emptied.
  - mem_we = 0; mem_addr = 0; mem_data = 0.
  - clear_done = 0; busy = 0; both counters = 0.
  - rst mid-clear aborts the clear with no clear_done pulse.
- **States:**
  - IDLE: FIFO empty, no clear.
  - RUN: FIFO non-empty; draining.
  - CLEAR: sweeping the screen.
- **Transitions:**
  - IDLE/RUN -> CLEAR when clear = 1. A write already presented (mem_we high) finishes its handshake first; then the sweep starts at address 0.
  - IDLE -> RUN on the first push.
  - RUN -> IDLE when the last entry is popped and no push happens that cycle.
  - CLEAR -> RUN (FIFO non-empty) or IDLE after the final address is accepted.
  - clear asserted while in CLEAR is ignored; it does not restart the sweep.
- **Plot intake**, every cycle vga_plot = 1, in any state:
  - Clip: if vga_x >= FB_WIDTH or vga_y >= FB_HEIGHT, the plot is discarded and clip_count increments. The clip check takes priority over the drop check.
  - Address: vga_y*160 + vga_x, computed as (y<<7)+(y<<5)+x. Result is 15 bits; the maximum is 19199.
  - Push: accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the plot is dropped and drop_count increments.
  - Both counters saturate at all-ones.
- **Write port:**
  - A plot registered at edge N may present mem_we at N+1 at the earliest.
  - mem_addr and mem_data are held stable while mem_we = 1 && mem_ready = 0.
  - Pop from the FIFO on acceptance.
  - Back-to-back writes are supported: one per cycle when mem_ready stays high.
- **CLEAR:**
  - Write clear_colour to addresses 0 .. FB_WIDTH*FB_HEIGHT-1 in order, one per accepted handshake.
  - The FIFO is not drained during CLEAR; plots still push and are dropped once the FIFO is full. Buffered plots are written after the clear, so they appear on top.
  - clear_done pulses in the cycle after the final accepted write.
- **busy** = (state == CLEAR) || FIFO non-empty.

Decomposition:
- Package `plot_pkg`:
  - FB_WIDTH, FB_HEIGHT, FB_PIXELS = 19200, ADDR_W = 15.
  - State enum {IDLE, RUN, CLEAR}.
  - Colour constants: BLACK 3'b000, RED 3'b100, GREEN 3'b010, BLUE 3'b001, WHITE 3'b111.
  - FIFO entry struct {addr, colour}.
- Sub-module `plot_fifo`: synchronous FIFO of the entry struct.
  - Ports: push, pop, full, empty.
  - Simultaneous push and pop when full is legal and keeps the count at full.

Test Plan:
- Single plot (x=10, y=5, colour=3'b100), mem_ready tied high -> exactly one write, addr=810, data=3'b100, one cycle after the plot edge; busy falls after it.
- Clip: plots (160,0) and (0,120), then (159,119) -> clip_count=2; one write at addr=19199.
- Backpressure: mem_ready=0; 6 consecutive plots with FIFO_DEPTH=4 -> drop_count=2. Then raise mem_ready -> 4 writes in push order; addr/data stable throughout the stall.
- Full with simultaneous pop: keep the FIFO full with mem_ready=1 and vga_plot high every cycle -> drop_count stays 0; one write per cycle.
- Clear: clear=1 with clear_colour=3'b111, mem_ready=1 -> 19200 writes at addrs 0..19199, data=3'b111. A plot (3,3) issued mid-clear is written at addr=483 after the sweep. clear_done pulses exactly once.
- Reset at sweep address 500 -> next cycle mem_we=0, counters=0, no clear_done pulse; a new clear restarts the sweep at address 0.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and constants for the pixel-plot capture path into the 160x120 framebuffer.
package plot_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CLEAR
  } state_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } entry_t;

  // y*160 + x built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pixelAddr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = {{(ADDR_W-7){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(ADDR_W-8){1'b0}}, x};
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO of plot entries; push while full is legal only together with a pop.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wrData,
  output entry_t                   rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PW:0]      r_wrPtr;
  logic [PW:0]      r_rdPtr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + 1'b1;
      if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // When full, the write slot equals the read slot; the head is read combinationally before it is overwritten.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wrPtr[PW-1:0]] <= wrData;
  end

  assign rdData = r_mem[r_rdPtr[PW-1:0]];
  assign count  = r_wrPtr - r_rdPtr;
  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/plot_capture.sv
// Clips engine plots to the screen, buffers them and writes them to the framebuffer; also sweeps a full-screen clear.
module plot_capture
  import plot_pkg::*;
#(
  parameter int FB_WIDTH   = plot_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = plot_pkg::FB_HEIGHT,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        vga_x,
  input  logic [6:0]        vga_y,
  input  logic [2:0]        vga_colour,
  input  logic              vga_plot,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  output logic              clear_done,
  output logic              busy,
  output logic [14:0]       mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  clip_count
);

  localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]        X_LIM     = 8'(FB_WIDTH);
  localparam logic [6:0]        Y_LIM     = 7'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_clearPend;
  logic [2:0]          r_clearColour;
  logic [ADDR_W-1:0]   r_clearAddr;
  logic                r_clearDone;
  logic [CNT_W-1:0]    r_dropCount;
  logic [CNT_W-1:0]    r_clipCount;

  entry_t              w_entry;
  entry_t              w_head;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_countNext;
  logic                w_inRange;
  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_clip;
  logic                w_clearReq;
  logic                w_clearGo;
  logic                w_lastClear;

  assign w_inRange   = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign w_entry     = '{addr: pixelAddr(vga_x, vga_y), colour: vga_colour};
  assign w_accept    = mem_we && mem_ready;
  assign w_pop       = w_accept && (r_state != CLEAR);
  assign w_push      = vga_plot && w_inRange && (!w_full || w_pop);
  assign w_drop      = vga_plot && w_inRange && w_full && !w_pop;
  assign w_clip      = vga_plot && !w_inRange;
  assign w_countNext = w_count + CW'(w_push) - CW'(w_pop);

  // A clear seen while a write is stalled is remembered until that handshake completes.
  assign w_clearReq  = (r_state != CLEAR) && (clear || r_clearPend);
  assign w_clearGo   = w_clearReq && !(mem_we && !mem_ready);
  assign w_lastClear = (r_state == CLEAR) && w_accept && (r_clearAddr == LAST_ADDR);

  plot_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .pop    (w_pop),
    .wrData (w_entry),
    .rdData (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (r_state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = r_clearAddr;
      mem_data = r_clearColour;
    end else if (!w_empty) begin
      mem_we   = 1'b1;
      mem_addr = w_head.addr;
      mem_data = w_head.colour;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE, RUN: begin
        if (w_clearGo)              w_nextState = CLEAR;
        else if (w_countNext != '0) w_nextState = RUN;
        else                        w_nextState = IDLE;
      end
      CLEAR: begin
        if (w_lastClear) w_nextState = (w_countNext != '0) ? RUN : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_clearPend   <= 1'b0;
      r_clearColour <= '0;
      r_clearAddr   <= '0;
      r_clearDone   <= 1'b0;
      r_dropCount   <= '0;
      r_clipCount   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_clearDone <= w_lastClear;
      r_clearPend <= w_clearReq && !w_clearGo;
      if (clear && (r_state != CLEAR) && !r_clearPend) r_clearColour <= clear_colour;
      if (w_clearGo)                           r_clearAddr <= '0;
      else if ((r_state == CLEAR) && w_accept) r_clearAddr <= r_clearAddr + 1'b1;
      if (w_drop && (r_dropCount != '1)) r_dropCount <= r_dropCount + 1'b1;
      if (w_clip && (r_clipCount != '1)) r_clipCount <= r_clipCount + 1'b1;
    end
  end

  assign clear_done = r_clearDone;
  assign busy       = (r_state == CLEAR) || !w_empty;
  assign drop_count = r_dropCount;
  assign clip_count = r_clipCount;

endmodule

// File: tb/tb_plot_capture.sv
// Directed bench for plot_capture: single plot, clipping, backpressure, full-with-pop, clear sweep and reset mid-clear.
module tb_plot_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic [15:0] drop_count;
  logic [15:0] clip_count;

  int          vectorCount = 0;
  int          missCount   = 0;
  int          clearDoneCnt = 0;
  logic [17:0] wq[$];

  plot_capture #(
    .FB_WIDTH   (160),
    .FB_HEIGHT  (120),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear        (clear),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .busy         (busy),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .drop_count   (drop_count),
    .clip_count   (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every accepted write and every clear_done cycle midway between edges.
  always @(negedge clk) begin
    if (mem_we && mem_ready) wq.push_back({mem_addr, mem_data});
    if (clear_done) clearDoneCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    vga_plot   = p;
    vga_x      = x;
    vga_y      = y;
    vga_colour = c;
    stepCycles(1);
  endtask

  initial begin
    int stallBad;
    int seqErr;
    int weBad;
    int waited;

    rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clear = 1'b0; clear_colour = '0; mem_ready = 1'b1;
    stepCycles(3);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_drop", drop_count, 0);
    checkOutput("rst_clip", clip_count, 0);
    rst = 1'b0;
    stepCycles(1);

    // Single plot, written one cycle after its edge.
    wq.delete();
    applyStimulus(1'b1, 8'd10, 7'd5, 3'b100);
    vga_plot = 1'b0;
    checkOutput("single_we", mem_we, 1);
    checkOutput("single_addr", mem_addr, 810);
    checkOutput("single_data", mem_data, 3'b100);
    checkOutput("single_busy", busy, 1);
    stepCycles(1);
    checkOutput("single_we_after", mem_we, 0);
    checkOutput("single_busy_after", busy, 0);
    stepCycles(2);
    checkOutput("single_writes", wq.size(), 1);

    // Clipping on both axes, then the bottom-right corner.
    wq.delete();
    applyStimulus(1'b1, 8'd160, 7'd0, 3'b010);
    applyStimulus(1'b1, 8'd0, 7'd120, 3'b010);
    applyStimulus(1'b1, 8'd159, 7'd119, 3'b010);
    vga_plot = 1'b0;
    stepCycles(3);
    checkOutput("clip_count", clip_count, 2);
    checkOutput("clip_writes", wq.size(), 1);
    if (wq.size() > 0) checkOutput("clip_corner", wq[0], {15'd19199, 3'b010});

    // Backpressure: six plots into a four-entry buffer.
    wq.delete();
    mem_ready = 1'b0;
    stallBad = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 7'd0, 3'(i + 1));
      if (!(mem_we && mem_addr == 15'd1 && mem_data == 3'd1)) stallBad++;
    end
    vga_plot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycles(1);
      if (!(mem_we && mem_addr == 15'd1 && mem_data == 3'd1)) stallBad++;
    end
    checkOutput("stall_stable", stallBad, 0);
    checkOutput("bp_drop", drop_count, 2);
    mem_ready = 1'b1;
    stepCycles(6);
    checkOutput("bp_writes", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++)
      checkOutput($sformatf("bp_entry%0d", i), wq[i], {15'(i + 1), 3'(i + 1)});
    checkOutput("bp_busy", busy, 0);

    // Full buffer with a pop every cycle keeps accepting.
    wq.delete();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(20 + k), 7'd1, 3'(k));
    mem_ready = 1'b1;
    weBad = 0;
    for (int k = 4; k < 14; k++) begin
      applyStimulus(1'b1, 8'(20 + k), 7'd1, 3'(k));
      if (!mem_we) weBad++;
    end
    vga_plot = 1'b0;
    stepCycles(4);
    checkOutput("full_pop_we", weBad, 0);
    checkOutput("full_pop_drop", drop_count, 2);
    checkOutput("full_pop_writes", wq.size(), 14);
    seqErr = 0;
    for (int k = 0; k < 14; k++)
      if (k >= wq.size() || wq[k] != {15'(180 + k), 3'(k)}) seqErr++;
    checkOutput("full_pop_order", seqErr, 0);

    // Full-screen clear with a plot issued mid-sweep.
    wq.delete();
    clearDoneCnt = 0;
    clear = 1'b1; clear_colour = 3'b111;
    stepCycles(1);
    clear = 1'b0;
    stepCycles(100);
    applyStimulus(1'b1, 8'd3, 7'd3, 3'b001);
    vga_plot = 1'b0;
    checkOutput("clear_busy", busy, 1);
    waited = 0;
    while (!clear_done && waited < 20000) begin
      stepCycles(1);
      waited++;
    end
    checkOutput("clear_done_seen", clear_done, 1);
    stepCycles(5);
    checkOutput("clear_done_pulses", clearDoneCnt, 1);
    checkOutput("clear_writes", wq.size(), 19201);
    seqErr = 0;
    for (int i = 0; i < 19200; i++)
      if (i >= wq.size() || wq[i] != {15'(i), 3'b111}) seqErr++;
    checkOutput("clear_seq", seqErr, 0);
    if (wq.size() > 19200) checkOutput("clear_plot_after", wq[19200], {15'd483, 3'b001});

    // Reset at sweep address 500 aborts silently; a new clear restarts at 0.
    clearDoneCnt = 0;
    clear = 1'b1; clear_colour = 3'b100;
    stepCycles(1);
    clear = 1'b0;
    waited = 0;
    while (!(mem_we && mem_addr == 15'd500) && waited < 1000) begin
      stepCycles(1);
      waited++;
    end
    checkOutput("sweep_reached_500", mem_addr, 500);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("abort_we", mem_we, 0);
    checkOutput("abort_drop", drop_count, 0);
    checkOutput("abort_clip", clip_count, 0);
    checkOutput("abort_busy", busy, 0);
    rst = 1'b0;
    stepCycles(3);
    checkOutput("abort_no_done", clearDoneCnt, 0);
    clear = 1'b1; clear_colour = 3'b010;
    stepCycles(1);
    clear = 1'b0;
    checkOutput("restart_we", mem_we, 1);
    checkOutput("restart_addr", mem_addr, 0);
    checkOutput("restart_data", mem_data, 3'b010);
    stepCycles(1);
    checkOutput("restart_addr_next", mem_addr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
